// File: rtl/ex_stage.sv
// tinyriscv execute stage: EX register feeding the ALU, EX/MEM output register,
// and branch/jump resolution producing a one-cycle front-end redirect.
module ex_stage #(
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              id_valid,
    output logic              id_ready,
    input  logic [31:0]       id_a,
    input  logic [31:0]       id_b,
    input  logic [4:0]        id_op,
    input  logic [31:0]       id_pc,
    input  logic [31:0]       id_imm,
    input  logic [1:0]        id_kind,
    input  logic [4:0]        id_rd,
    input  logic              id_wen,
    input  logic [CTRL_W-1:0] id_ctrl,

    output logic [31:0]       alu_a,
    output logic [31:0]       alu_b,
    output logic [4:0]        alu_op,
    output logic [31:0]       alu_pc,
    input  logic [31:0]       alu_c,
    input  logic              alu_zero,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output logic [4:0]        out_rd,
    output logic              out_wen,
    output logic [CTRL_W-1:0] out_ctrl,

    output logic              redirect_valid,
    output logic [31:0]       redirect_pc
);

    localparam logic [4:0] ALUOP_nop = 5'd0;

    typedef enum logic [1:0] {
        KIND_PLAIN  = 2'd0,
        KIND_BRANCH = 2'd1,
        KIND_JAL    = 2'd2,
        KIND_JALR   = 2'd3
    } kind_e;

    logic              ex_valid;
    logic [31:0]       ex_a;
    logic [31:0]       ex_b;
    logic [4:0]        ex_op;
    logic [31:0]       ex_pc;
    logic [31:0]       ex_imm;
    kind_e             ex_kind;
    logic [4:0]        ex_rd;
    logic              ex_wen;
    logic [CTRL_W-1:0] ex_ctrl;

    logic              advance;
    logic              taken;
    logic [31:0]       target;
    logic [31:0]       link;

    assign advance  = ex_valid & (~out_valid | out_ready);
    assign id_ready = ~ex_valid | advance;

    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = ALUOP_nop;
        alu_pc = '0;
        if (ex_valid) begin
            alu_a  = ex_a;
            alu_b  = ex_b;
            alu_op = ex_op;
            alu_pc = ex_pc;
        end
    end

    always_comb begin
        taken  = 1'b0;
        target = ex_pc + ex_imm;
        link   = ex_pc + 32'd4;
        case (ex_kind)
            KIND_BRANCH: taken = alu_zero;
            KIND_JAL:    taken = 1'b1;
            KIND_JALR: begin
                taken  = 1'b1;
                target = (ex_a + ex_imm) & ~32'd1;
            end
            default:     taken = 1'b0;
        endcase
    end

    assign redirect_valid = advance & taken;
    assign redirect_pc    = redirect_valid ? target : '0;

    // An ID handshake in a redirect cycle is on the wrong path, so EX empties instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid <= 1'b0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_op    <= ALUOP_nop;
            ex_pc    <= '0;
            ex_imm   <= '0;
            ex_kind  <= KIND_PLAIN;
            ex_rd    <= '0;
            ex_wen   <= 1'b0;
            ex_ctrl  <= '0;
        end else if (id_ready) begin
            ex_valid <= id_valid & ~redirect_valid;
            if (id_valid) begin
                ex_a    <= id_a;
                ex_b    <= id_b;
                ex_op   <= id_op;
                ex_pc   <= id_pc;
                ex_imm  <= id_imm;
                ex_kind <= kind_e'(id_kind);
                ex_rd   <= id_rd;
                ex_wen  <= id_wen;
                ex_ctrl <= id_ctrl;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_rd     <= '0;
            out_wen    <= 1'b0;
            out_ctrl   <= '0;
        end else if (advance) begin
            out_valid  <= 1'b1;
            out_result <= (ex_kind == KIND_JAL || ex_kind == KIND_JALR) ? link : alu_c;
            out_rd     <= ex_rd;
            out_wen    <= ex_wen & (ex_kind != KIND_BRANCH);
            out_ctrl   <= ex_ctrl;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed instructions push expected EX/MEM payloads
// and redirect targets; a negedge monitor compares whatever the DUT presents.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_a, id_b, id_pc, id_imm;
    logic [4:0]  id_op, id_rd;
    logic [1:0]  id_kind;
    logic        id_wen;
    logic [7:0]  id_ctrl;
    logic [31:0] alu_a, alu_b, alu_pc, alu_c;
    logic [4:0]  alu_op;
    logic        alu_zero;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic [7:0]  out_ctrl;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    logic [45:0] exp_q[$];
    logic [31:0] red_q[$];

    localparam logic [4:0] OP_NOP = 5'd0, OP_ADD = 5'd1, OP_BEQ = 5'd8,
                           OP_BNE = 5'd9, OP_BLT = 5'd10, OP_BLTU = 5'd11;

    always #5 clk = ~clk;

    ex_stage #(.CTRL_W(8)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_a(id_a), .id_b(id_b), .id_op(id_op), .id_pc(id_pc), .id_imm(id_imm),
        .id_kind(id_kind), .id_rd(id_rd), .id_wen(id_wen), .id_ctrl(id_ctrl),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_pc(alu_pc),
        .alu_c(alu_c), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .out_wen(out_wen), .out_ctrl(out_ctrl),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    // ALU model: branch ops yield zero exactly when the branch is taken
    always_comb begin
        case (alu_op)
            OP_ADD:  alu_c = alu_a + alu_b;
            OP_BEQ:  alu_c = alu_a - alu_b;
            OP_BNE:  alu_c = (alu_a != alu_b) ? 32'd0 : 32'd1;
            OP_BLT:  alu_c = ($signed(alu_a) < $signed(alu_b)) ? 32'd0 : 32'd1;
            OP_BLTU: alu_c = (alu_a < alu_b) ? 32'd0 : 32'd1;
            default: alu_c = 32'd0;
        endcase
        alu_zero = (alu_c == 32'd0);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("out_unexpected", 64'(out_result), 64'hDEAD);
                end else begin
                    chk("out_payload", 64'({out_result, out_rd, out_wen, out_ctrl}), 64'(exp_q[0]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (redirect_valid) begin
                if (red_q.size() == 0) chk("redirect_unexpected", 64'(redirect_pc), 64'hDEAD);
                else chk("redirect_pc", 64'(redirect_pc), 64'(red_q.pop_front()));
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                         input logic [31:0] pc, input logic [31:0] imm, input logic [1:0] kind,
                         input logic [4:0] rd, input logic wen, input logic [7:0] ctrl,
                         input logic [31:0] exp_res, input logic exp_wen,
                         input bit exp_redir, input logic [31:0] exp_rpc, input bit drop);
        int unsigned n;
        id_a = a; id_b = b; id_op = op; id_pc = pc; id_imm = imm; id_kind = kind;
        id_rd = rd; id_wen = wen; id_ctrl = ctrl; id_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (id_ready) break;
            n++;
            if (n > 100) begin
                chk("issue_timeout", 64'(id_ready), 64'd1);
                return;
            end
        end
        if (!drop) begin
            exp_q.push_back({exp_res, rd, exp_wen, ctrl});
            if (exp_redir) red_q.push_back(exp_rpc);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int unsigned cycles);
        id_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; id_valid = 1'b0; out_ready = 1'b1;
        id_a = '0; id_b = '0; id_op = '0; id_pc = '0; id_imm = '0;
        id_kind = '0; id_rd = '0; id_wen = 1'b0; id_ctrl = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_id_ready", 64'(id_ready), 64'd1);
        chk("rst_alu_op", 64'(alu_op), 64'(OP_NOP));
        chk("rst_out_payload", 64'({out_result, out_rd, out_wen, out_ctrl}), 64'd0);
        chk("rst_redirect", 64'({redirect_valid, redirect_pc}), 64'd0);
        @(posedge clk); #1;

        // single add, two-edge latency
        issue(5, 7, OP_ADD, 32'h40, 0, 2'd0, 5'd3, 1'b1, 8'h5A, 32'd12, 1'b1, 0, 0, 0);
        id_valid = 1'b0;
        @(negedge clk);
        chk("lat_out_valid_n1", 64'(out_valid), 64'd0);
        chk("lat_alu_ops", 64'({alu_a, alu_b}), {32'd5, 32'd7});
        chk("lat_alu_op_pc", 64'({alu_op, alu_pc}), 64'({OP_ADD, 32'h40}));
        @(negedge clk);
        chk("lat_out_valid_n2", 64'(out_valid), 64'd1);
        idle(3);

        // back-to-back with 3-cycle MEM stall
        out_ready = 1'b0;
        fork
            begin
                repeat (3) @(negedge clk);
                chk("stall_id_ready", 64'(id_ready), 64'd0);
                chk("stall_out_valid", 64'(out_valid), 64'd1);
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join_none
        issue(1, 2, OP_ADD, 0, 0, 2'd0, 5'd4, 1'b1, 8'h01, 32'd3, 1'b1, 0, 0, 0);
        issue(10, 20, OP_ADD, 0, 0, 2'd0, 5'd5, 1'b1, 8'h02, 32'd30, 1'b1, 0, 0, 0);
        issue(32'hFFFFFFFF, 2, OP_ADD, 0, 0, 2'd0, 5'd6, 1'b1, 8'h03, 32'd1, 1'b1, 0, 0, 0);
        idle(4);

        // branches and jumps; the instruction right behind a taken one is flushed
        issue(9, 9, OP_BEQ, 32'h100, 32'h20, 2'd1, 5'd0, 1'b1, 8'h11, 32'd0, 1'b0, 1, 32'h120, 0);
        issue(1, 1, OP_ADD, 32'h104, 0, 2'd0, 5'd7, 1'b1, 8'h12, 32'd2, 1'b1, 0, 0, 1);
        issue(2, 2, OP_ADD, 32'h120, 0, 2'd0, 5'd8, 1'b1, 8'h13, 32'd4, 1'b1, 0, 0, 0);
        issue(9, 9, OP_BNE, 32'h100, 32'h20, 2'd1, 5'd0, 1'b1, 8'h14, 32'd1, 1'b0, 0, 0, 0);
        issue(32'hFFFFFFFF, 1, OP_BLT, 32'h100, 32'h20, 2'd1, 5'd0, 1'b1, 8'h15, 32'd0, 1'b0, 1, 32'h120, 0);
        issue(3, 3, OP_ADD, 32'h104, 0, 2'd0, 5'd9, 1'b1, 8'h16, 32'd6, 1'b1, 0, 0, 1);
        issue(32'hFFFFFFFF, 1, OP_BLTU, 32'h100, 32'h20, 2'd1, 5'd0, 1'b1, 8'h17, 32'd1, 1'b0, 0, 0, 0);
        issue(32'h1003, 4, OP_ADD, 32'h200, 32'd4, 2'd3, 5'd1, 1'b1, 8'h18, 32'h204, 1'b1, 1, 32'h1006, 0);
        issue(4, 4, OP_ADD, 32'h204, 0, 2'd0, 5'd9, 1'b1, 8'h19, 32'd8, 1'b1, 0, 0, 1);
        issue(0, 0, OP_ADD, 32'hFFFFFFF0, 32'h20, 2'd2, 5'd2, 1'b1, 8'h1A, 32'hFFFFFFF4, 1'b1, 1, 32'h10, 0);
        issue(5, 5, OP_ADD, 32'hFFFFFFF4, 0, 2'd0, 5'd9, 1'b1, 8'h1B, 32'd10, 1'b1, 0, 0, 1);
        issue(6, 7, OP_ADD, 32'h10, 0, 2'd0, 5'd11, 1'b1, 8'h1C, 32'd13, 1'b1, 0, 0, 0);
        idle(4);

        // taken beq stalled behind a blocked out register for two cycles
        out_ready = 1'b0;
        fork
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join_none
        issue(8, 8, OP_ADD, 32'h300, 0, 2'd0, 5'd12, 1'b1, 8'h21, 32'd16, 1'b1, 0, 0, 0);
        issue(9, 9, OP_BEQ, 32'h304, 32'h40, 2'd1, 5'd0, 1'b1, 8'h22, 32'd0, 1'b0, 1, 32'h344, 0);
        issue(1, 1, OP_ADD, 32'h308, 0, 2'd0, 5'd13, 1'b1, 8'h23, 32'd2, 1'b1, 0, 0, 1);
        issue(7, 1, OP_ADD, 32'h344, 0, 2'd0, 5'd14, 1'b1, 8'h24, 32'd8, 1'b1, 0, 0, 0);
        idle(4);

        // reset with both registers full (second one a jal that must not redirect)
        out_ready = 1'b0;
        issue(3, 3, OP_ADD, 32'h400, 0, 2'd0, 5'd15, 1'b1, 8'h31, 32'd6, 1'b1, 0, 0, 0);
        issue(0, 0, OP_ADD, 32'h404, 32'h10, 2'd2, 5'd16, 1'b1, 8'h32, 32'h408, 1'b1, 0, 0, 0);
        id_valid = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        red_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst2_out_valid", 64'(out_valid), 64'd0);
        chk("rst2_id_ready", 64'(id_ready), 64'd1);
        chk("rst2_alu_op", 64'(alu_op), 64'(OP_NOP));
        chk("rst2_redirect", 64'(redirect_valid), 64'd0);
        idle(6);

        chk("drain_out_queue", 64'(exp_q.size()), 64'd0);
        chk("drain_redirect_queue", 64'(red_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute-stage pipeline block for the tinyriscv core: the issuing side of the ALU interface. It accepts decoded instructions from ID over a valid/ready handshake and holds them in an EX register. It drives the ALU operand, op and PC lines, then captures the ALU result into an EX/MEM output register. It also resolves branches and jumps from the ALU `Zero` flag and issues a one-cycle front-end redirect.

## Interface
- CTRL_W, 8, width of opaque MEM/WB control bits passed through unchanged
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID presents an instruction
- id_ready  out  1  EX register can accept this cycle
- id_a, id_b  in  32 each  ALU operands (rs1 value; rs2 value or immediate)
- id_op  in  5  ALU op code, `ALUOP_*` from def.vh
- id_pc  in  32  instruction PC
- id_imm  in  32  branch/jump offset
- id_kind  in  2  0 plain, 1 conditional branch, 2 jal, 3 jalr
- id_rd  in  5  destination register
- id_wen  in  1  register write enable
- id_ctrl  in  CTRL_W  pass-through control
- alu_a, alu_b  out  32 each  to ALU A, B
- alu_op  out  5  to ALU op
- alu_pc  out  32  to ALU PC
- alu_c  in  32  ALU result
- alu_zero  in  1  ALU Zero flag
- out_valid  out  1  EX/MEM register holds an instruction
- out_ready  in  1  MEM accepts
- out_result, out_rd, out_wen, out_ctrl  out  32/5/1/CTRL_W  EX/MEM payload
- redirect_valid  out  1  taken branch/jump, front end must refetch
- redirect_pc  out  32  target

## Operation
- State: EX register (ex_valid plus the latched id_* fields) and out register (out_valid plus payload).
- alu_a/alu_b/alu_op/alu_pc are driven from the EX register. When ex_valid=0, alu_op=`ALUOP_nop` and the other ALU outputs are 0.
- advance = ex_valid & (~out_valid | out_ready). id_ready = ~ex_valid | advance.
- On advance, the out register loads:
  - out_result = alu_c for kind 0/1.
  - out_result = ex_pc+4 for kind 2/3 (link value; ALU output ignored).
  - rd, wen, ctrl are copied from the EX register.
  - wen is forced to 0 for kind 1.
- Branch taken rule, kind 1: taken = alu_zero for every branch op. The ALU branch encodings produce zero exactly when the branch is taken.
- Jump targets:
  - kind 1/2: target = ex_pc + ex_imm.
  - kind 3: target = (ex_a + ex_imm) & ~1.
  - kind 2/3 are always taken.
- redirect_valid = advance & taken, combinational from registers and ALU. It lasts exactly one cycle per taken instruction.
- Flush: in a redirect cycle, any ID instruction handshaken that cycle is dropped. The EX register goes empty (ex_valid=0) rather than loading it.
- If an out register entry is consumed without a new advance (out_valid & out_ready & ~advance), out_valid clears.
- All arithmetic is 32-bit modulo 2^32; target and link wrap silently.
- Reset values:
  - ex_valid=0, out_valid=0, redirect_valid=0.
  - out_result/out_rd/out_wen/out_ctrl=0, redirect_pc=0.
  - alu_op=`ALUOP_nop`.
- Reset takes priority over every handshake and discards any in-flight instruction.

## Timing
- Accept at edge N puts the instruction in EX during cycle N+1. ALU outputs are valid that cycle.
- If MEM is not stalling, the result appears on out_* in cycle N+2 (latency 2 edges). Throughput is one per cycle.
- Back-pressure: out_ready=0 with out_valid=1 holds both registers.
  - id_ready drops in the same cycle if EX is full.
  - No payload changes while stalled.
- A stalled branch does not redirect until the cycle it advances. redirect_valid is never asserted while stalled.
- Simultaneous out consume and EX advance: the out register reloads, out_valid stays 1.
- Simultaneous ID accept and advance: the EX register reloads, unless a redirect occurs (then it empties).
- redirect_pc is meaningful only while redirect_valid=1. It is held 0 otherwise.

## Test plan
- Reset, then add: id a=5 b=7 op=add rd=3 wen=1, out_ready=1 → two cycles later out_valid=1, out_result=12, out_rd=3. redirect_valid never asserts.
- Back-to-back with stall: three add instructions, out_ready=0 for 3 cycles → id_ready low after EX fills, payload stable, then all three are delivered in order once out_ready=1.
- Branches at pc=0x100, imm=0x20:
  - beq a=b=9 → redirect_valid one cycle, redirect_pc=0x120, out_wen=0, same-cycle ID instruction dropped.
  - bne a=b=9 → no redirect.
  - blt a=-1 b=1 → taken.
  - bltu a=0xFFFFFFFF b=1 → not taken.
- jalr a=0x1003 imm=4 pc=0x200 rd=1 → redirect_pc=0x1006, out_result=0x204.
- Stalled branch: taken beq held by out_ready=0 for 2 cycles → redirect_valid only in the release cycle, exactly once.
- rst asserted with both registers full → next cycle out_valid=0, id_ready=1, alu_op=`ALUOP_nop`, no redirect.
